orc_mem_arbiter: RTL and testbench
==================================

# orc_mem_arbiter

Three-way arbiter sharing one single-port memory bus between the ORC_R32I instruction-read, data-read and data-write interfaces. Sits between the core and the unified program/data memory, which includes the console MMIO word at 32'h1000_0000. Grants one requester at a time in round-robin order and converts the core's level-held requests into single-cycle command strobes. Guards every transaction with a timeout so a dead slave cannot hang the core.

## Interface
- TIMEOUT_CYCLES, 255: cycles after a strobe before a missing ack is declared a bus error (1..255).
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- i_inst_read  in  1  instruction fetch request, held until ack.
- i_inst_read_addr  in  32  fetch address.
- o_inst_read_ack  out  1  one-cycle fetch completion.
- o_inst_read_data  out  32  fetch data, valid with ack.
- i_master_read  in  1  data load request, held until ack.
- i_master_read_addr  in  32  load address.
- o_master_read_ack  out  1  one-cycle load completion.
- o_master_read_data  out  32  load data, valid with ack.
- i_master_write  in  1  store request, held until ack.
- i_master_write_addr  in  32  store address.
- i_master_write_data  in  32  store data.
- i_master_write_byte_enable  in  4  store lane enables.
- o_master_write_ack  out  1  one-cycle store completion.
- o_mem_read  out  1  one-cycle downstream read strobe.
- o_mem_write  out  1  one-cycle downstream write strobe.
- o_mem_addr  out  32  downstream address.
- o_mem_wdata  out  32  downstream write data; 0 on reads.
- o_mem_byte_enable  out  4  store enables on writes; 4'hF on reads.
- i_mem_ack  in  1  downstream completion.
- i_mem_rdata  in  32  downstream read data, valid with i_mem_ack.
- o_bus_error  out  1  one-cycle pulse on timeout.

## Operation
- Requester indices: 0 = inst, 1 = data read, 2 = data write.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: when any request is high, choose the first active requester scanning from last_grant+1 mod 3. Latch grant, address, data and byte enables. Go to ISSUE.
- ISSUE: drive o_mem_read or o_mem_write high for exactly this cycle with the latched fields. Clear the timeout counter. Go to WAIT.
- WAIT: o_mem_* strobes low; address, wdata and byte enables stay at the latched values.
  - On i_mem_ack: pulse the granted requester's ack and register i_mem_rdata to its data port (loads and fetches only). Update last_grant. Go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: same completion with data 32'h0, plus an o_bus_error pulse.
- RELEASE: one cycle with no arbitration, so a held request that was just acked is not re-granted. Go to IDLE.
- A request dropped after grant does not abort the transaction; the downstream access completes and the ack is still pulsed.
- i_mem_ack in IDLE, ISSUE or RELEASE is ignored. A late ack after a timeout is ignored if it lands outside WAIT; if it lands in a later WAIT it completes that transaction (documented limitation).
- Console writes to 32'h1000_0000 get no special handling; they are ordinary writes.

## Timing
- Reset values:
  - all acks, strobes and o_bus_error: 0
  - data outputs, o_mem_addr, o_mem_wdata: 32'h0
  - o_mem_byte_enable: 4'h0
  - state: IDLE; last_grant: 2, so inst has first priority.
- Request sampled in cycle 0 → strobe in cycle 1. Ack seen in cycle k ≥ 2 → requester ack and data in cycle k+1, state RELEASE. IDLE again in cycle k+2.
- With a 1-cycle memory the minimum is 4 cycles per transaction; this is the back-to-back throughput.
- Simultaneous requests are served one per transaction in rotation. No requester waits more than two other transactions.
- resetn low in any state: return to IDLE at the next edge, drop any in-flight ack, clear outputs.
- Timeout counter is 8 bits and saturates at TIMEOUT_CYCLES.

## Structure
- Package orc_arb_pkg:
  - state enum
  - REQ_INST / REQ_RD / REQ_WR index constants
  - CONSOLE_ADDR constant, shared with benches.
- Sub-module orc_rr_pick3: combinational 3-way round-robin picker. Inputs: req[2:0], last[1:0]. Outputs: grant index and valid.

## Test plan
- Fetch alone at 0x0000_0010, memory word 32'h0000_0013, 1-cycle memory → o_mem_read in cycle 1, o_inst_read_ack with 32'h0000_0013 in cycle 3. No second strobe while the request is held through cycle 3.
- All three requests held continuously from reset → grant order inst, read, write, inst. Each completion 4 cycles apart.
- Store of 32'hA5A5_A5A5 with byte enable 4'b0011 to 0x100 → o_mem_write strobe with byte enable 4'b0011. Readback load returns 32'hxxxx_A5A5 in the low lanes with the upper bytes unchanged.
- Silent slave with TIMEOUT_CYCLES=8 → o_master_read_ack with 32'h0 and o_bus_error pulse 8 cycles after the strobe. Next request is served normally.
- resetn asserted during WAIT → next cycle all outputs zero, state IDLE. The pending ack never appears.
- Store to 32'h1000_0000 with data 8'h41 → single o_mem_write strobe at that address, then o_master_write_ack.

Source files
------------

// File: rtl/orc_mem_arbiter_pkg.sv
// Shared types and constants for the ORC_R32I memory arbiter.
package orc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0]  REQ_INST = 2'd0;
  localparam logic [1:0]  REQ_RD   = 2'd1;
  localparam logic [1:0]  REQ_WR   = 2'd2;

  // Console MMIO word; the arbiter treats it as ordinary memory.
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;

  // Next requester index in rotation; an out-of-range index wraps to inst.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx >= REQ_WR) nxt = REQ_INST;
    else               nxt = idx + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/orc_mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first active request after 'last'.
module orc_rr_pick3
  import orc_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // Scan order is last+1, last+2, last+3 (mod 3).
  always_comb begin
    c0    = rr_next(last);
    c1    = rr_next(c0);
    c2    = rr_next(c1);
    valid = |req;
    grant = REQ_INST;
    if (req[c0])      grant = c0;
    else if (req[c1]) grant = c1;
    else if (req[c2]) grant = c2;
  end

endmodule

// File: rtl/orc_mem_arbiter.sv
// Round-robin arbiter putting inst-fetch, data-read and data-write requests
// onto one single-port memory bus, with a per-transaction ack timeout.
module orc_mem_arbiter
  import orc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_inst_read,
  input  logic [31:0] i_inst_read_addr,
  output logic        o_inst_read_ack,
  output logic [31:0] o_inst_read_data,
  input  logic        i_master_read,
  input  logic [31:0] i_master_read_addr,
  output logic        o_master_read_ack,
  output logic [31:0] o_master_read_data,
  input  logic        i_master_write,
  input  logic [31:0] i_master_write_addr,
  input  logic [31:0] i_master_write_data,
  input  logic [3:0]  i_master_write_byte_enable,
  output logic        o_master_write_ack,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_byte_enable,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_error
);

  localparam logic [8:0] TMO9 = 9'(TIMEOUT_CYCLES);
  localparam logic [7:0] TMO8 = 8'(TIMEOUT_CYCLES);

  arb_state_t state;
  arb_state_t state_next;

  logic [1:0]  last_grant;
  logic [1:0]  grant;
  logic [7:0]  cnt;
  logic [8:0]  cnt_inc;

  logic [1:0]  pick_grant;
  logic        pick_valid;

  logic        do_grant;
  logic        do_complete;
  logic        timed_out;

  orc_rr_pick3 u_pick (
    .req   ({i_master_write, i_master_read, i_inst_read}),
    .last  (last_grant),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // cnt is cleared on the grant edge, so it reads 0 in ISSUE and counts
  // cycles since the strobe; timeout fires when the next count hits the limit.
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and transaction control decode.
  always_comb begin
    state_next  = state;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    timed_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_mem_ack) begin
          do_complete = 1'b1;
          state_next  = ST_RELEASE;
        end else if (cnt_inc >= TMO9) begin
          do_complete = 1'b1;
          timed_out   = 1'b1;
          state_next  = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Timeout counter, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= 8'd0;
    end else if (do_grant) begin
      cnt <= 8'd0;
    end else if (state == ST_ISSUE || state == ST_WAIT) begin
      cnt <= (cnt_inc >= TMO9) ? TMO8 : cnt_inc[7:0];
    end
  end

  // Grant latch and downstream command fields; strobes last one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant             <= REQ_INST;
      o_mem_read        <= 1'b0;
      o_mem_write       <= 1'b0;
      o_mem_addr        <= 32'h0;
      o_mem_wdata       <= 32'h0;
      o_mem_byte_enable <= 4'h0;
    end else begin
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      if (do_grant) begin
        grant <= pick_grant;
        case (pick_grant)
          REQ_WR: begin
            o_mem_write       <= 1'b1;
            o_mem_addr        <= i_master_write_addr;
            o_mem_wdata       <= i_master_write_data;
            o_mem_byte_enable <= i_master_write_byte_enable;
          end
          REQ_RD: begin
            o_mem_read        <= 1'b1;
            o_mem_addr        <= i_master_read_addr;
            o_mem_wdata       <= 32'h0;
            o_mem_byte_enable <= 4'hF;
          end
          default: begin
            o_mem_read        <= 1'b1;
            o_mem_addr        <= i_inst_read_addr;
            o_mem_wdata       <= 32'h0;
            o_mem_byte_enable <= 4'hF;
          end
        endcase
      end
    end
  end

  // Completion: one-cycle requester ack, read data capture, bus error pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant         <= REQ_WR;
      o_inst_read_ack    <= 1'b0;
      o_inst_read_data   <= 32'h0;
      o_master_read_ack  <= 1'b0;
      o_master_read_data <= 32'h0;
      o_master_write_ack <= 1'b0;
      o_bus_error        <= 1'b0;
    end else begin
      o_inst_read_ack    <= 1'b0;
      o_master_read_ack  <= 1'b0;
      o_master_write_ack <= 1'b0;
      o_bus_error        <= 1'b0;
      if (do_complete) begin
        last_grant  <= grant;
        o_bus_error <= timed_out;
        case (grant)
          REQ_WR: o_master_write_ack <= 1'b1;
          REQ_RD: begin
            o_master_read_ack  <= 1'b1;
            o_master_read_data <= timed_out ? 32'h0 : i_mem_rdata;
          end
          default: begin
            o_inst_read_ack  <= 1'b1;
            o_inst_read_data <= timed_out ? 32'h0 : i_mem_rdata;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orc_mem_arbiter.sv
// Directed bench for orc_mem_arbiter with a 1-cycle memory responder.
module tb_orc_mem_arbiter;
  import orc_arb_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        resetn;
  logic        i_inst_read;
  logic [31:0] i_inst_read_addr;
  logic        o_inst_read_ack;
  logic [31:0] o_inst_read_data;
  logic        i_master_read;
  logic [31:0] i_master_read_addr;
  logic        o_master_read_ack;
  logic [31:0] o_master_read_data;
  logic        i_master_write;
  logic [31:0] i_master_write_addr;
  logic [31:0] i_master_write_data;
  logic [3:0]  i_master_write_byte_enable;
  logic        o_master_write_ack;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_byte_enable;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'h0;
  logic        o_bus_error;

  logic        slave_alive;
  logic        strobe_prev = 1'b0;
  logic [31:0] rdata_pend = 32'h0;
  logic [31:0] mem [0:255];
  int          console_writes = 0;
  logic [7:0]  console_last = 8'h0;

  int n_cmp = 0;
  int n_err = 0;
  int cw0;

  orc_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .i_inst_read                (i_inst_read),
    .i_inst_read_addr           (i_inst_read_addr),
    .o_inst_read_ack            (o_inst_read_ack),
    .o_inst_read_data           (o_inst_read_data),
    .i_master_read              (i_master_read),
    .i_master_read_addr         (i_master_read_addr),
    .o_master_read_ack          (o_master_read_ack),
    .o_master_read_data         (o_master_read_data),
    .i_master_write             (i_master_write),
    .i_master_write_addr        (i_master_write_addr),
    .i_master_write_data        (i_master_write_data),
    .i_master_write_byte_enable (i_master_write_byte_enable),
    .o_master_write_ack         (o_master_write_ack),
    .o_mem_read                 (o_mem_read),
    .o_mem_write                (o_mem_write),
    .o_mem_addr                 (o_mem_addr),
    .o_mem_wdata                (o_mem_wdata),
    .o_mem_byte_enable          (o_mem_byte_enable),
    .i_mem_ack                  (i_mem_ack),
    .i_mem_rdata                (i_mem_rdata),
    .o_bus_error                (o_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack and data one cycle after a strobe; contents reload in reset.
  always @(negedge clk) begin
    i_mem_ack   = strobe_prev;
    i_mem_rdata = strobe_prev ? rdata_pend : 32'h0;
    strobe_prev = 1'b0;
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4]  = 32'h0000_0013;
      mem[8]  = 32'hCAFE_F00D;
      mem[64] = 32'h1234_5678;
    end
    if (o_mem_read === 1'b1) begin
      strobe_prev = slave_alive;
      rdata_pend  = mem[o_mem_addr[9:2]];
    end else if (o_mem_write === 1'b1) begin
      strobe_prev = slave_alive;
      if (o_mem_addr == CONSOLE_ADDR) begin
        console_writes++;
        console_last = o_mem_wdata[7:0];
      end else if (resetn) begin
        for (int b = 0; b < 4; b++)
          if (o_mem_byte_enable[b]) mem[o_mem_addr[9:2]][8*b +: 8] = o_mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    slave_alive = 1'b1;
    i_inst_read = 1'b0;   i_inst_read_addr = 32'h0;
    i_master_read = 1'b0; i_master_read_addr = 32'h0;
    i_master_write = 1'b0; i_master_write_addr = 32'h0;
    i_master_write_data = 32'h0; i_master_write_byte_enable = 4'h0;
    repeat (3) step();

    // reset values
    chk("rst_inst_ack", 32'(o_inst_read_ack), 32'h0);
    chk("rst_rd_ack", 32'(o_master_read_ack), 32'h0);
    chk("rst_wr_ack", 32'(o_master_write_ack), 32'h0);
    chk("rst_strobes", {30'h0, o_mem_read, o_mem_write}, 32'h0);
    chk("rst_bus_err", 32'(o_bus_error), 32'h0);
    chk("rst_inst_data", o_inst_read_data, 32'h0);
    chk("rst_rd_data", o_master_read_data, 32'h0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_be", 32'(o_mem_byte_enable), 32'h0);

    // single fetch, request held through its ack
    resetn = 1'b1;
    i_inst_read = 1'b1; i_inst_read_addr = 32'h0000_0010;
    step();
    chk("f_c1_read", 32'(o_mem_read), 32'h1);
    chk("f_c1_write", 32'(o_mem_write), 32'h0);
    chk("f_c1_addr", o_mem_addr, 32'h0000_0010);
    chk("f_c1_be", 32'(o_mem_byte_enable), 32'hF);
    chk("f_c1_wdata", o_mem_wdata, 32'h0);
    step();
    chk("f_c2_read", 32'(o_mem_read), 32'h0);
    chk("f_c2_ack", 32'(o_inst_read_ack), 32'h0);
    step();
    chk("f_c3_ack", 32'(o_inst_read_ack), 32'h1);
    chk("f_c3_data", o_inst_read_data, 32'h0000_0013);
    chk("f_c3_read", 32'(o_mem_read), 32'h0);
    step();
    chk("f_c4_read", 32'(o_mem_read), 32'h0);
    chk("f_c4_ack", 32'(o_inst_read_ack), 32'h0);
    i_inst_read = 1'b0;
    step();
    chk("f_c5_read", 32'(o_mem_read), 32'h0);

    // all three held from reset: inst, read, write, inst
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    i_inst_read = 1'b1;   i_inst_read_addr = 32'h0000_0010;
    i_master_read = 1'b1; i_master_read_addr = 32'h0000_0020;
    i_master_write = 1'b1; i_master_write_addr = 32'h0000_0030;
    i_master_write_data = 32'hDEAD_BEEF; i_master_write_byte_enable = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("rr_c%0d_inst_ack", c), 32'(o_inst_read_ack), 32'((c == 3) || (c == 15)));
      chk($sformatf("rr_c%0d_rd_ack", c), 32'(o_master_read_ack), 32'(c == 7));
      chk($sformatf("rr_c%0d_wr_ack", c), 32'(o_master_write_ack), 32'(c == 11));
      if (c == 7)  chk("rr_rd_data", o_master_read_data, 32'hCAFE_F00D);
      if (c == 9)  chk("rr_wr_strobe", 32'(o_mem_write), 32'h1);
      if (c == 15) chk("rr_inst_data", o_inst_read_data, 32'h0000_0013);
    end
    i_inst_read = 1'b0; i_master_read = 1'b0; i_master_write = 1'b0;
    step();
    step();
    chk("rr_idle_strobes", {30'h0, o_mem_read, o_mem_write}, 32'h0);

    // partial-byte store then readback
    i_master_write = 1'b1; i_master_write_addr = 32'h0000_0100;
    i_master_write_data = 32'hA5A5_A5A5; i_master_write_byte_enable = 4'b0011;
    step();
    chk("st_c1_write", 32'(o_mem_write), 32'h1);
    chk("st_c1_read", 32'(o_mem_read), 32'h0);
    chk("st_c1_addr", o_mem_addr, 32'h0000_0100);
    chk("st_c1_be", 32'(o_mem_byte_enable), 32'h3);
    chk("st_c1_wdata", o_mem_wdata, 32'hA5A5_A5A5);
    step();
    step();
    chk("st_c3_ack", 32'(o_master_write_ack), 32'h1);
    i_master_write = 1'b0;
    step();
    i_master_read = 1'b1; i_master_read_addr = 32'h0000_0100;
    step();
    chk("ld_c1_read", 32'(o_mem_read), 32'h1);
    chk("ld_c1_be", 32'(o_mem_byte_enable), 32'hF);
    chk("ld_c1_wdata", o_mem_wdata, 32'h0);
    step();
    step();
    chk("ld_c3_ack", 32'(o_master_read_ack), 32'h1);
    chk("ld_c3_data", o_master_read_data, 32'h1234_A5A5);
    i_master_read = 1'b0;
    step();

    // silent slave: timeout completes the load with zero data and an error
    slave_alive = 1'b0;
    i_master_read = 1'b1; i_master_read_addr = 32'h0000_0020;
    step();
    chk("to_c1_read", 32'(o_mem_read), 32'h1);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("to_c%0d_ack", c), 32'(o_master_read_ack), 32'h0);
      chk($sformatf("to_c%0d_err", c), 32'(o_bus_error), 32'h0);
    end
    step();
    chk("to_c9_ack", 32'(o_master_read_ack), 32'h1);
    chk("to_c9_err", 32'(o_bus_error), 32'h1);
    chk("to_c9_data", o_master_read_data, 32'h0);
    i_master_read = 1'b0;
    slave_alive = 1'b1;
    step();
    chk("to_c10_err", 32'(o_bus_error), 32'h0);
    i_master_read = 1'b1; i_master_read_addr = 32'h0000_0020;
    step();
    chk("to_next_read", 32'(o_mem_read), 32'h1);
    step();
    step();
    chk("to_next_ack", 32'(o_master_read_ack), 32'h1);
    chk("to_next_data", o_master_read_data, 32'hCAFE_F00D);
    i_master_read = 1'b0;
    step();

    // reset while waiting for the ack
    i_inst_read = 1'b1; i_inst_read_addr = 32'h0000_0010;
    step();
    chk("rw_c1_read", 32'(o_mem_read), 32'h1);
    step();
    resetn = 1'b0;
    step();
    chk("rw_inst_ack", 32'(o_inst_read_ack), 32'h0);
    chk("rw_inst_data", o_inst_read_data, 32'h0);
    chk("rw_rd_data", o_master_read_data, 32'h0);
    chk("rw_addr", o_mem_addr, 32'h0);
    chk("rw_be", 32'(o_mem_byte_enable), 32'h0);
    chk("rw_strobes", {30'h0, o_mem_read, o_mem_write}, 32'h0);
    resetn = 1'b1;
    i_inst_read = 1'b0;
    step();
    chk("rw_c4_ack", 32'(o_inst_read_ack), 32'h0);
    step();
    chk("rw_c5_ack", 32'(o_inst_read_ack), 32'h0);
    chk("rw_c5_strobes", {30'h0, o_mem_read, o_mem_write}, 32'h0);

    // console store is an ordinary single write
    cw0 = console_writes;
    i_master_write = 1'b1; i_master_write_addr = CONSOLE_ADDR;
    i_master_write_data = 32'h0000_0041; i_master_write_byte_enable = 4'b0001;
    step();
    chk("con_c1_write", 32'(o_mem_write), 32'h1);
    chk("con_c1_addr", o_mem_addr, 32'h1000_0000);
    chk("con_c1_wdata", o_mem_wdata, 32'h0000_0041);
    chk("con_c1_be", 32'(o_mem_byte_enable), 32'h1);
    step();
    step();
    chk("con_c3_ack", 32'(o_master_write_ack), 32'h1);
    i_master_write = 1'b0;
    step();
    step();
    chk("con_count", 32'(console_writes - cw0), 32'h1);
    chk("con_byte", 32'(console_last), 32'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
